// File: rtl/neuron_sched_ctrl.sv
// Sweep sequencer for neuron_core and the synapse array: AER events, time-step and
// sample-end sweeps over post-neuron SRAM words, plus single-word SPI access while idle.
module neuron_sched_ctrl #(
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int AER_WIDTH            = 12,
  parameter int TIME_STEP            = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_aer_req,
  input  logic [AER_WIDTH-1:0]            i_aer_addr,
  output logic                            o_aer_ack,
  input  logic                            i_tstep_req,
  input  logic                            i_tref_req,
  input  logic                            i_spi_gate_activity_sync,
  input  logic                            i_spi_rd_req,
  input  logic                            i_spi_wr_req,
  input  logic [POST_NEUR_ADDR_WIDTH-1:0] i_spi_post_neur_addr,
  output logic                            o_spi_done,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  o_ctrl_pre_neuron_address,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] o_ctrl_post_neuron_address,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] o_ctrl_synarray_addr,
  output logic                            o_ctrl_synarray_cs,
  output logic                            o_ctrl_neur_event,
  output logic                            o_ctrl_tstep_event,
  output logic                            o_ctrl_tref_event,
  output logic                            o_ctrl_pre_neur_cs,
  output logic                            o_ctrl_pre_neur_we,
  output logic                            o_ctrl_post_neur_cs,
  output logic                            o_ctrl_post_neur_we,
  output logic                            o_ctrl_pre_cnt_en,
  output logic                            o_ctrl_wr_neur_event,
  output logic                            o_ctrl_rd_neur_event,
  output logic [$clog2(TIME_STEP)-1:0]    o_tstep_cnt,
  output logic                            o_busy
);

  localparam int W      = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int WORD_W = $clog2(W);
  localparam int LANE_W = $clog2(POST_NEUR_PARALLEL);
  localparam int TS_W   = $clog2(TIME_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_UPD, S_POST_RD, S_POST_WR, S_PRE_CLR, S_ACK_HOLD, S_SPI_RD, S_SPI_WR
  } state_t;

  typedef enum logic [1:0] {OP_AER, OP_TSTEP, OP_TREF} op_t;

  state_t                         r_state, w_next;
  op_t                            r_op, w_op_next;
  logic [WORD_W-1:0]              r_word;
  logic [PRE_NEUR_ADDR_WIDTH-1:0] r_pre;
  logic [PRE_NEUR_ADDR_WIDTH-1:0] r_aer_addr;
  logic [TS_W-1:0]                r_tstep_cnt;
  logic                           r_tstep_pend, r_tref_pend, r_spi_rd_d;
  logic                           w_aer_start, w_tstep_start, w_tref_start;
  logic                           w_last_word, w_last_pre, w_aer_oob;

  assign w_last_word = (r_word == WORD_W'(W - 1));
  assign w_last_pre  = (r_pre == PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1));
  assign w_aer_oob   = (i_aer_addr >= AER_WIDTH'(INPUT_NEURON));
  assign o_tstep_cnt = r_tstep_cnt;
  assign o_busy      = (r_state != S_IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= OP_AER;
      r_word       <= '0;
      r_pre        <= '0;
      r_aer_addr   <= '0;
      r_tstep_cnt  <= '0;
      r_tstep_pend <= 1'b0;
      r_tref_pend  <= 1'b0;
      r_spi_rd_d   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_op         <= w_op_next;
      r_tref_pend  <= (r_tref_pend & ~w_tref_start) | i_tref_req;
      r_tstep_pend <= (r_tstep_pend & ~w_tstep_start) | i_tstep_req;
      r_spi_rd_d   <= (r_state == S_SPI_RD);
      if (w_aer_start) r_aer_addr <= i_aer_addr[PRE_NEUR_ADDR_WIDTH-1:0];
      if (r_state == S_IDLE)         r_word <= '0;
      else if (r_state == S_POST_WR) r_word <= r_word + 1'b1;
      r_pre <= (r_state == S_PRE_CLR) ? r_pre + 1'b1 : '0;
      if (r_state == S_POST_WR && w_last_word && r_op == OP_TSTEP)
        r_tstep_cnt <= (r_tstep_cnt == TS_W'(TIME_STEP - 1)) ? '0 : r_tstep_cnt + 1'b1;
      else if (r_state == S_PRE_CLR && w_last_pre)
        r_tstep_cnt <= '0;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next                     = r_state;
    w_op_next                  = r_op;
    w_aer_start                = 1'b0;
    w_tstep_start              = 1'b0;
    w_tref_start               = 1'b0;
    o_aer_ack                  = 1'b0;
    o_spi_done                 = r_spi_rd_d;
    o_ctrl_pre_neuron_address  = '0;
    o_ctrl_post_neuron_address = '0;
    o_ctrl_synarray_addr       = '0;
    o_ctrl_synarray_cs         = 1'b0;
    o_ctrl_neur_event          = 1'b0;
    o_ctrl_tstep_event         = 1'b0;
    o_ctrl_tref_event          = 1'b0;
    o_ctrl_pre_neur_cs         = 1'b0;
    o_ctrl_pre_neur_we         = 1'b0;
    o_ctrl_post_neur_cs        = 1'b0;
    o_ctrl_post_neur_we        = 1'b0;
    o_ctrl_pre_cnt_en          = 1'b0;
    o_ctrl_wr_neur_event       = 1'b0;
    o_ctrl_rd_neur_event       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_spi_gate_activity_sync) begin
          if (r_tref_pend) begin
            w_next = S_POST_RD; w_op_next = OP_TREF; w_tref_start = 1'b1;
          end else if (r_tstep_pend) begin
            w_next = S_POST_RD; w_op_next = OP_TSTEP; w_tstep_start = 1'b1;
          end else if (i_aer_req) begin
            w_aer_start = 1'b1;
            w_op_next   = OP_AER;
            w_next      = w_aer_oob ? S_ACK_HOLD : S_PRE_UPD;
          end
        end else if (i_spi_wr_req) begin
          w_next = S_SPI_WR;
        end else if (i_spi_rd_req) begin
          w_next = S_SPI_RD;
        end
      end
      S_PRE_UPD: begin
        o_ctrl_pre_neur_cs        = 1'b1;
        o_ctrl_pre_neur_we        = 1'b1;
        o_ctrl_pre_cnt_en         = 1'b1;
        o_ctrl_neur_event         = 1'b1;
        o_ctrl_pre_neuron_address = r_aer_addr;
        w_next                    = S_POST_RD;
      end
      S_POST_RD, S_POST_WR: begin
        o_ctrl_post_neur_cs        = 1'b1;
        o_ctrl_post_neur_we        = (r_state == S_POST_WR);
        o_ctrl_post_neuron_address = POST_NEUR_ADDR_WIDTH'({r_word, {LANE_W{1'b0}}});
        o_ctrl_neur_event          = (r_op == OP_AER);
        o_ctrl_tstep_event         = (r_op == OP_TSTEP);
        o_ctrl_tref_event          = (r_op == OP_TREF);
        if (r_op == OP_AER) begin
          o_ctrl_pre_neuron_address = r_aer_addr;
          o_ctrl_synarray_addr      = SYN_ARRAY_ADDR_WIDTH'({r_aer_addr, r_word});
          o_ctrl_synarray_cs        = (r_state == S_POST_RD);
        end
        if (r_state == S_POST_RD) w_next = S_POST_WR;
        else if (!w_last_word)    w_next = S_POST_RD;
        else if (r_op == OP_AER)  w_next = S_ACK_HOLD;
        else if (r_op == OP_TREF) w_next = S_PRE_CLR;
        else                      w_next = S_IDLE;
      end
      S_PRE_CLR: begin
        o_ctrl_pre_neur_cs        = 1'b1;
        o_ctrl_pre_neur_we        = 1'b1;
        o_ctrl_tref_event         = 1'b1;
        o_ctrl_pre_neuron_address = r_pre;
        if (w_last_pre) w_next = S_IDLE;
      end
      S_ACK_HOLD: begin
        o_aer_ack = 1'b1;
        if (!i_aer_req) w_next = S_IDLE;
      end
      S_SPI_RD: begin
        o_ctrl_post_neur_cs        = 1'b1;
        o_ctrl_rd_neur_event       = 1'b1;
        o_ctrl_post_neuron_address = i_spi_post_neur_addr;
        w_next                     = S_IDLE;
      end
      S_SPI_WR: begin
        o_ctrl_post_neur_cs        = 1'b1;
        o_ctrl_post_neur_we        = 1'b1;
        o_ctrl_wr_neur_event       = 1'b1;
        o_ctrl_post_neuron_address = i_spi_post_neur_addr;
        o_spi_done                 = 1'b1;
        w_next                     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_sched_ctrl.sv
// Directed bench for neuron_sched_ctrl: AER, TSTEP, TREF sweeps, pending/priority, SPI, reset.
module tb_neuron_sched_ctrl;

  logic        clk, rst_n;
  logic        aer_req, aer_ack, tstep_req, tref_req;
  logic [11:0] aer_addr;
  logic        spi_gate, spi_rd_req, spi_wr_req, spi_done;
  logic [9:0]  spi_addr, pre_addr, post_addr;
  logic [15:0] syn_addr;
  logic        syn_cs, neur_ev, tstep_ev, tref_ev;
  logic        pre_cs, pre_we, post_cs, post_we, pre_cnt_en, wr_ev, rd_ev, busy;
  logic [2:0]  tstep_cnt;
  logic [52:0] all_out;

  int checks = 0;
  int errors = 0;

  assign all_out = {aer_ack, spi_done, pre_addr, post_addr, syn_addr, syn_cs, neur_ev, tstep_ev,
                    tref_ev, pre_cs, pre_we, post_cs, post_we, pre_cnt_en, wr_ev, rd_ev, tstep_cnt, busy};

  neuron_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_aer_req(aer_req), .i_aer_addr(aer_addr), .o_aer_ack(aer_ack),
    .i_tstep_req(tstep_req), .i_tref_req(tref_req),
    .i_spi_gate_activity_sync(spi_gate), .i_spi_rd_req(spi_rd_req), .i_spi_wr_req(spi_wr_req),
    .i_spi_post_neur_addr(spi_addr), .o_spi_done(spi_done),
    .o_ctrl_pre_neuron_address(pre_addr), .o_ctrl_post_neuron_address(post_addr),
    .o_ctrl_synarray_addr(syn_addr), .o_ctrl_synarray_cs(syn_cs),
    .o_ctrl_neur_event(neur_ev), .o_ctrl_tstep_event(tstep_ev), .o_ctrl_tref_event(tref_ev),
    .o_ctrl_pre_neur_cs(pre_cs), .o_ctrl_pre_neur_we(pre_we),
    .o_ctrl_post_neur_cs(post_cs), .o_ctrl_post_neur_we(post_we),
    .o_ctrl_pre_cnt_en(pre_cnt_en),
    .o_ctrl_wr_neur_event(wr_ev), .o_ctrl_rd_neur_event(rd_ev),
    .o_tstep_cnt(tstep_cnt), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 5) begin cyc(); n++; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s: sweep did not start, busy=%b", name, busy); end
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!aer_ack && n < 200) begin cyc(); n++; end
    checks++;
    if (aer_ack !== 1'b1) begin errors++; $display("FAIL %s: ack timeout, ack=%b", name, aer_ack); end
  endtask

  task automatic test_reset();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    #22 rst_n = 1'b1;
    cyc();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_idle: got %h want 0", all_out); end
  endtask

  task automatic test_aer_in_range();
    aer_addr = 12'd5;
    aer_req  = 1'b1;
    cyc();
    checks++;
    if ({pre_cs, pre_we, pre_cnt_en, neur_ev, post_cs, pre_addr} !== {5'b11110, 10'd5}) begin
      errors++;
      $display("FAIL aer_pre_upd: got cs/we/cnt/ev/post=%b%b%b%b%b addr=%0d want 11110 addr=5",
               pre_cs, pre_we, pre_cnt_en, neur_ev, post_cs, pre_addr);
    end
    for (int j = 0; j < 128; j++) begin
      cyc();
      checks++;
      if (post_cs !== 1'b1 || post_we !== j[0] || syn_cs !== !j[0] || pre_cnt_en !== 1'b0 ||
          neur_ev !== 1'b1 || aer_ack !== 1'b0 || pre_cs !== 1'b0 ||
          syn_addr !== 16'(5 * 64 + j / 2) || post_addr !== 10'((j / 2) * 4)) begin
        errors++;
        $display("FAIL aer_post[%0d]: cs=%b we=%b syncs=%b ev=%b syn=%0d post=%0d want we=%0d syn=%0d post=%0d",
                 j, post_cs, post_we, syn_cs, neur_ev, syn_addr, post_addr, j % 2, 5 * 64 + j / 2, (j / 2) * 4);
      end
    end
    cyc();
    checks++;
    if (aer_ack !== 1'b1 || neur_ev !== 1'b0 || post_cs !== 1'b0) begin
      errors++; $display("FAIL aer_ack_rise: ack=%b ev=%b post_cs=%b want 1 0 0", aer_ack, neur_ev, post_cs);
    end
    cyc(); cyc();
    aer_req = 1'b0;
    checks++;
    if (aer_ack !== 1'b1) begin errors++; $display("FAIL aer_ack_hold: got %b want 1", aer_ack); end
    cyc();
    checks++;
    if (aer_ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL aer_ack_drop: ack=%b busy=%b want 0 0", aer_ack, busy);
    end
  endtask

  task automatic test_aer_out_of_range();
    aer_addr = 12'd800;
    aer_req  = 1'b1;
    cyc();
    checks++;
    if (aer_ack !== 1'b1 || pre_cs !== 1'b0 || post_cs !== 1'b0 || syn_cs !== 1'b0 || pre_cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL aer_oob: ack=%b pre_cs=%b post_cs=%b syn_cs=%b cnt=%b want 1 0 0 0 0",
               aer_ack, pre_cs, post_cs, syn_cs, pre_cnt_en);
    end
    aer_req = 1'b0;
    cyc();
    checks++;
    if (aer_ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL aer_oob_drop: ack=%b busy=%b want 0 0", aer_ack, busy);
    end
  endtask

  task automatic test_tstep_wrap();
    for (int n = 0; n < 8; n++) begin
      int len = 0;
      tstep_req = 1'b1;
      cyc();
      tstep_req = 1'b0;
      wait_busy("tstep_start");
      while (busy && len < 300) begin
        checks++;
        if (tstep_ev !== 1'b1 || post_cs !== 1'b1 || syn_cs !== 1'b0 || pre_cs !== 1'b0 ||
            tstep_cnt !== 3'(n)) begin
          errors++;
          $display("FAIL tstep_sweep[%0d]: ev=%b post_cs=%b syn_cs=%b pre_cs=%b cnt=%0d want 1 1 0 0 cnt=%0d",
                   len, tstep_ev, post_cs, syn_cs, pre_cs, tstep_cnt, n);
        end
        len++;
        cyc();
      end
      checks++;
      if (len != 128 || tstep_cnt !== 3'((n + 1) % 8)) begin
        errors++; $display("FAIL tstep_len: len=%0d cnt=%0d want 128 cnt=%0d", len, tstep_cnt, (n + 1) % 8);
      end
    end
  endtask

  task automatic test_pend_priority();
    int len = 0;
    aer_addr = 12'd5;
    aer_req  = 1'b1;
    repeat (10) cyc();
    tstep_req = 1'b1;
    tref_req  = 1'b1;
    cyc();
    tstep_req = 1'b0;
    tref_req  = 1'b0;
    repeat (5) cyc();
    tstep_req = 1'b1;
    cyc();
    tstep_req = 1'b0;
    wait_ack("prio_aer_ack");
    aer_req = 1'b0;
    cyc();
    wait_busy("tref_start");
    checks++;
    if (tref_ev !== 1'b1 || tstep_ev !== 1'b0) begin
      errors++; $display("FAIL prio_order: tref=%b tstep=%b want 1 0", tref_ev, tstep_ev);
    end
    while (busy && len < 1000) begin
      checks++;
      if (len < 128) begin
        if (tref_ev !== 1'b1 || post_cs !== 1'b1 || post_we !== len[0] || pre_cs !== 1'b0) begin
          errors++; $display("FAIL tref_post[%0d]: ev=%b cs=%b we=%b pre_cs=%b", len, tref_ev, post_cs, post_we, pre_cs);
        end
      end else if (tref_ev !== 1'b1 || pre_cs !== 1'b1 || pre_we !== 1'b1 || post_cs !== 1'b0 ||
                   pre_addr !== 10'(len - 128)) begin
        errors++;
        $display("FAIL tref_clr[%0d]: ev=%b cs=%b we=%b post_cs=%b addr=%0d want addr=%0d",
                 len, tref_ev, pre_cs, pre_we, post_cs, pre_addr, len - 128);
      end
      len++;
      cyc();
    end
    checks++;
    if (len != 912 || tstep_cnt !== 3'd0) begin
      errors++; $display("FAIL tref_len: len=%0d cnt=%0d want 912 cnt=0", len, tstep_cnt);
    end
    wait_busy("prio_tstep_start");
    len = 0;
    while (busy && len < 300) begin
      checks++;
      if (tstep_ev !== 1'b1 || tref_ev !== 1'b0) begin
        errors++; $display("FAIL prio_tstep[%0d]: tstep=%b tref=%b want 1 0", len, tstep_ev, tref_ev);
      end
      len++;
      cyc();
    end
    checks++;
    if (len != 128 || tstep_cnt !== 3'd1) begin
      errors++; $display("FAIL prio_tstep_len: len=%0d cnt=%0d want 128 cnt=1", len, tstep_cnt);
    end
    repeat (4) cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL prio_merge: busy=%b want 0", busy); end
  endtask

  task automatic test_spi();
    int len = 1;
    tstep_req = 1'b1;
    cyc();
    tstep_req = 1'b0;
    wait_busy("spi_tstep_start");
    spi_gate   = 1'b1;
    spi_wr_req = 1'b1;
    spi_addr   = 10'd9;
    cyc();
    spi_wr_req = 1'b0;
    while (busy && len < 300) begin
      checks++;
      if (tstep_ev !== 1'b1 || wr_ev !== 1'b0) begin
        errors++; $display("FAIL spi_gate_sweep[%0d]: tstep=%b wr=%b want 1 0", len, tstep_ev, wr_ev);
      end
      len++;
      cyc();
    end
    checks++;
    if (len != 128 || tstep_cnt !== 3'd2) begin
      errors++; $display("FAIL spi_gate_len: len=%0d cnt=%0d want 128 cnt=2", len, tstep_cnt);
    end
    aer_addr = 12'd5;
    aer_req  = 1'b1;
    repeat (3) begin
      cyc();
      checks++;
      if (busy !== 1'b0 || aer_ack !== 1'b0) begin
        errors++; $display("FAIL spi_aer_holdoff: busy=%b ack=%b want 0 0", busy, aer_ack);
      end
    end
    spi_wr_req = 1'b1;
    cyc();
    spi_wr_req = 1'b0;
    checks++;
    if ({wr_ev, rd_ev, post_cs, post_we, spi_done} !== 5'b10111 || post_addr !== 10'd9 || post_addr[9:2] !== 8'd2) begin
      errors++;
      $display("FAIL spi_wr: wr/rd/cs/we/done=%b%b%b%b%b addr=%0d want 10111 addr=9",
               wr_ev, rd_ev, post_cs, post_we, spi_done, post_addr);
    end
    cyc();
    checks++;
    if (spi_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL spi_wr_end: done=%b busy=%b want 0 0", spi_done, busy);
    end
    spi_addr   = 10'd12;
    spi_rd_req = 1'b1;
    cyc();
    spi_rd_req = 1'b0;
    checks++;
    if ({wr_ev, rd_ev, post_cs, post_we, spi_done} !== 5'b01100 || post_addr !== 10'd12) begin
      errors++;
      $display("FAIL spi_rd: wr/rd/cs/we/done=%b%b%b%b%b addr=%0d want 01100 addr=12",
               wr_ev, rd_ev, post_cs, post_we, spi_done, post_addr);
    end
    cyc();
    checks++;
    if (spi_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL spi_rd_done: done=%b busy=%b want 1 0", spi_done, busy);
    end
    spi_rd_req = 1'b1;
    spi_wr_req = 1'b1;
    cyc();
    spi_rd_req = 1'b0;
    spi_wr_req = 1'b0;
    checks++;
    if (wr_ev !== 1'b1 || rd_ev !== 1'b0) begin
      errors++; $display("FAIL spi_wr_wins: wr=%b rd=%b want 1 0", wr_ev, rd_ev);
    end
    cyc();
    spi_gate = 1'b0;
    cyc();
    checks++;
    if (pre_cnt_en !== 1'b1 || pre_addr !== 10'd5) begin
      errors++; $display("FAIL spi_aer_release: cnt_en=%b addr=%0d want 1 5", pre_cnt_en, pre_addr);
    end
    wait_ack("spi_aer_ack");
    aer_req = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL spi_aer_end: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_sweep();
    aer_addr = 12'd5;
    aer_req  = 1'b1;
    repeat (62) cyc();
    checks++;
    if (post_addr !== 10'd120 || post_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pos: post=%0d we=%b want 120 0", post_addr, post_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rst_mid_async: got %h want 0", all_out); end
    aer_req = 1'b0;
    #3 rst_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if (busy !== 1'b0 || aer_ack !== 1'b0 || tstep_cnt !== 3'd0) begin
      errors++; $display("FAIL rst_mid_after: busy=%b ack=%b cnt=%0d want 0 0 0", busy, aer_ack, tstep_cnt);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    aer_req    = 1'b0;
    aer_addr   = '0;
    tstep_req  = 1'b0;
    tref_req   = 1'b0;
    spi_gate   = 1'b0;
    spi_rd_req = 1'b0;
    spi_wr_req = 1'b0;
    spi_addr   = '0;
    #1;
    test_reset();
    test_aer_in_range();
    test_aer_out_of_range();
    test_tstep_wrap();
    test_pend_priority();
    test_spi();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
